// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory-port arbiter:
// arbiter state encoding, grant encoding and default bus widths.
package mips_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int TIMER_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DM_ACC = 2'd1,
        IF_ACC = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-cycle counter for one memory access; tc flags the last cycle the
// arbiter is willing to wait before abandoning the access.
module arb_wait_timer
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds the wait cycles already spent, so tc marks the TIMEOUT-th one
    assign tc = enable && (count == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// load/store, and derives the pipeline hold signals from the acks.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              mem_stall,
    output logic              bus_err
);

    arb_state_t state, next_state;
    grant_t     last_grant;

    logic dm_pending, if_pending;
    logic grant_dm, grant_if, finish;
    logic in_access, timer_tc;

    // A requester acked this cycle is still showing its old request; mask it
    assign dm_pending = (dm_read | dm_write) & ~dm_ack;
    assign if_pending = if_req & ~if_ack;
    assign in_access  = (state == DM_ACC) || (state == IF_ACC);

    arb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (grant_dm | grant_if | finish),
        .enable(in_access),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_dm   = 1'b0;
        grant_if   = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (dm_pending && (!if_pending || last_grant == GNT_IF)) begin
                    next_state = DM_ACC;
                    grant_dm   = 1'b1;
                end else if (if_pending) begin
                    next_state = IF_ACC;
                    grant_if   = 1'b1;
                end
            end
            DM_ACC, IF_ACC: begin
                if (mem_ready || timer_tc) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Access strobes, captured data and acks; a timed-out access returns zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= GNT_DM;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            bus_err    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            if (grant_dm) begin
                mem_en    <= 1'b1;
                mem_we    <= dm_write;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (finish) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                if (!mem_ready) begin
                    bus_err <= 1'b1;
                end
                if (state == DM_ACC) begin
                    dm_ack     <= 1'b1;
                    dm_rdata   <= mem_ready ? mem_rdata : '0;
                    last_grant <= GNT_DM;
                end else begin
                    if_ack     <= 1'b1;
                    if_rdata   <= mem_ready ? mem_rdata : '0;
                    last_grant <= GNT_IF;
                end
            end
        end
    end

    assign pc_write    = if_ack;
    assign if_id_write = if_ack;
    assign mem_stall   = (dm_read | dm_write) & ~dm_ack;

endmodule
